// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - FIFO-buffered byte launcher for the UART wrapper send/is_sending handshake
// Bytes queue in a sync FIFO; each is launched with a 1-cycle pulse, tracked through is_sending, then spaced by a gap.
module uart_tx_feeder #(
  parameter int AW            = 4,
  parameter int GAP_CYCLES    = 2,
  parameter int START_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          uart_send,
  output logic [7:0]    uart_data,
  input  logic          uart_busy,
  output logic          busy,
  output logic [15:0]   bytes_sent,
  output logic          overflow,
  output logic          timeout_err
);
  localparam int DEPTH = 1 << AW;
  localparam int TW    = $clog2(START_TIMEOUT + 1);
  localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_UP, WAIT_DOWN, GAP} state_t;

  // With no gap configured, a finished or abandoned byte returns straight to IDLE.
  localparam state_t AFTER_BYTE = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_t          state;
  state_t          state_next;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [TW-1:0]   tcnt;
  logic [GW-1:0]   gcnt;
  logic            pop;
  logic            push;
  logic            timeout_hit;
  logic            tx_done;

  assign full  = (level == (AW + 1)'(DEPTH));
  assign empty = (level == '0);
  assign busy  = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (!empty) state_next = WAIT_UP;
      WAIT_UP:   if (uart_busy) state_next = WAIT_DOWN;
                 else if (timeout_hit) state_next = AFTER_BYTE;
      WAIT_DOWN: if (!uart_busy) state_next = AFTER_BYTE;
      GAP:       if (gcnt == GW'(GAP_CYCLES - 1)) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    pop         = (state == IDLE) && !empty;
    push        = wr_en && (!full || pop);
    timeout_hit = (state == WAIT_UP) && !uart_busy && (tcnt == TW'(START_TIMEOUT - 1));
    tx_done     = (state == WAIT_DOWN) && !uart_busy;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      uart_send   <= 1'b0;
      uart_data   <= 8'h00;
      bytes_sent  <= 16'h0000;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
      tcnt        <= '0;
      gcnt        <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
      if (wr_en && !push) overflow <= 1'b1;

      uart_send <= pop;
      if (pop) begin
        uart_data <= mem[rd_ptr];
        tcnt      <= '0;
      end else if ((state == WAIT_UP) && !uart_busy && !timeout_hit) begin
        tcnt <= tcnt + 1'b1;
      end

      if (timeout_hit) timeout_err <= 1'b1;
      if (tx_done)     bytes_sent  <= bytes_sent + 1'b1;

      if (tx_done || timeout_hit) gcnt <= '0;
      else if (state == GAP)      gcnt <= gcnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - randomized scoreboard bench for uart_tx_feeder
// A queue/timestamp model predicts every output each cycle; directed scenarios pin its timing with literals.
module tb_uart_tx_feeder;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int GAP   = 2;
  localparam int TMO   = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        uart_busy = 1'b0;
  logic        full;
  logic        empty;
  logic [AW:0] level;
  logic        uart_send;
  logic [7:0]  uart_data;
  logic        busy;
  logic [15:0] bytes_sent;
  logic        overflow;
  logic        timeout_err;

  uart_tx_feeder #(.AW(AW), .GAP_CYCLES(GAP), .START_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level),
    .uart_send(uart_send), .uart_data(uart_data), .uart_busy(uart_busy),
    .busy(busy), .bytes_sent(bytes_sent), .overflow(overflow), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, m_cyc);
    end
  endtask

  // Model: byte queue, one in-flight byte, and the earliest edge a new launch may occur.
  int          m_cyc = 0;
  bit          m_valid = 0;
  logic [7:0]  m_q[$];
  bit          m_inflight = 0;
  bit          m_seen = 0;
  bit          m_send = 0;
  bit          m_ovf = 0;
  bit          m_to = 0;
  int          m_launch = 0;
  int          m_earliest = 0;
  logic [7:0]  m_data = 8'h00;
  logic [15:0] m_sent = 16'h0000;

  always @(posedge clk) begin
    bit pop;
    m_cyc++;
    if (rst) begin
      m_q.delete();
      m_inflight = 0; m_seen = 0; m_send = 0; m_ovf = 0; m_to = 0;
      m_earliest = 0; m_data = 8'h00; m_sent = 16'h0000; m_valid = 1;
    end else begin
      pop = !m_inflight && (m_cyc >= m_earliest) && (m_q.size() > 0);
      m_send = 0;
      if (m_inflight) begin
        if (!m_seen) begin
          if (uart_busy) m_seen = 1;
          else if (m_cyc - m_launch == TMO) begin
            m_to = 1; m_inflight = 0; m_earliest = m_cyc + GAP + 1;
          end
        end else if (!uart_busy) begin
          m_sent = m_sent + 16'h1; m_inflight = 0; m_earliest = m_cyc + GAP + 1;
        end
      end
      if (pop) begin
        m_data = m_q.pop_front();
        m_send = 1; m_inflight = 1; m_seen = 0; m_launch = m_cyc;
      end
      if (wr_en) begin
        if (m_q.size() < DEPTH) m_q.push_back(wr_data);
        else m_ovf = 1;
      end
    end
  end

  // UART wrapper stand-in: busy rises resp_delay edges after a send, stays up resp_hold edges.
  int resp_delay = 1;
  int resp_hold = 1;
  bit resp_never = 0;
  int r_dly = 0;
  int r_hold = 0;

  always @(posedge clk) begin
    #1;
    if (uart_send === 1'b1) begin
      uart_busy = 1'b0;
      r_dly  = resp_never ? 0 : resp_delay;
      r_hold = resp_never ? 0 : resp_hold;
    end else if (r_dly > 0) begin
      r_dly--;
      if (r_dly == 0) uart_busy = 1'b1;
    end else if (r_hold > 0) begin
      r_hold--;
      if (r_hold == 0) uart_busy = 1'b0;
    end
  end

  int          pulse_cyc[$];
  logic [7:0]  sent_log[$];
  int          bs_cyc[$];
  logic [15:0] bs_val[$];
  logic [15:0] bs_prev = 16'h0000;

  always @(negedge clk) begin
    if (m_valid) begin
      chk("uart_send", uart_send, m_send);
      chk("uart_data", uart_data, m_data);
      chk("level", level, m_q.size());
      chk("full", full, m_q.size() == DEPTH);
      chk("empty", empty, m_q.size() == 0);
      chk("busy", busy, m_inflight || (m_q.size() != 0) || (m_cyc + 1 < m_earliest));
      chk("bytes_sent", bytes_sent, m_sent);
      chk("overflow", overflow, m_ovf);
      chk("timeout_err", timeout_err, m_to);
    end
    if (uart_send === 1'b1) begin
      pulse_cyc.push_back(m_cyc);
      sent_log.push_back(uart_data);
    end
    if (bytes_sent !== bs_prev) begin
      bs_cyc.push_back(m_cyc);
      bs_val.push_back(bytes_sent);
      bs_prev = bytes_sent;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    pulse_cyc.delete(); sent_log.delete(); bs_cyc.delete(); bs_val.delete();
  endtask

  task automatic do_reset();
    wr_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || uart_busy || level != 0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) chk("wait_idle_bound", 1, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int n;
    int npulse;
    int pct;

    // Reset state and single-byte latency / gap timing
    tick();
    do_reset();
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_send", uart_send, 0);
    chk("rst_data", uart_data, 0);
    chk("rst_bytes", bytes_sent, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_to", timeout_err, 0);
    chk("rst_busy", busy, 0);
    resp_delay = 1; resp_hold = 20; resp_never = 0;
    write_byte(8'hA5);
    k = m_cyc;
    write_byte(8'hB6);
    wait_idle(300);
    chk("t1_pulses", pulse_cyc.size(), 2);
    if (pulse_cyc.size() == 2) begin
      chk("t1_first_launch", pulse_cyc[0], k + 1);
      chk("t1_data0", sent_log[0], 8'hA5);
      chk("t1_spacing", pulse_cyc[1] - pulse_cyc[0], 25);
      chk("t1_data1", sent_log[1], 8'hB6);
    end
    chk("t1_count_changes", bs_cyc.size(), 2);
    if (bs_cyc.size() >= 1) chk("t1_count_edge", bs_cyc[0] - k, 23);
    chk("t1_bytes", bytes_sent, 2);

    // Timed-out blocker, burst to full, rejected 17th byte
    do_reset();
    resp_never = 1; resp_delay = 1; resp_hold = 3;
    write_byte(8'h5A);
    for (int i = 0; i < 16; i++) write_byte(8'(i));
    write_byte(8'hFF);
    resp_never = 0;
    chk("t2_level", level, 16);
    chk("t2_full", full, 1);
    chk("t2_ovf", overflow, 1);
    chk("t2_to", timeout_err, 1);
    chk("t2_bytes_mid", bytes_sent, 0);
    wait_idle(2000);
    chk("t2_nsent", sent_log.size(), 17);
    if (sent_log.size() == 17) begin
      chk("t2_blocker", sent_log[0], 8'h5A);
      for (int i = 0; i < 16; i++) chk("t2_order", sent_log[i + 1], i);
    end
    chk("t2_bytes", bytes_sent, 16);
    chk("t2_empty", empty, 1);

    // Write into a full FIFO on the very edge IDLE pops
    do_reset();
    resp_delay = 1; resp_hold = 40;
    for (int i = 0; i < 17; i++) write_byte(8'(8'h20 + i));
    chk("t3_level", level, 16);
    chk("t3_full", full, 1);
    n = 0;
    while (!(!m_inflight && (m_cyc + 1 >= m_earliest) && m_q.size() > 0) && n < 300) begin
      tick();
      n++;
    end
    chk("t3_pop_wait_bound", n < 300, 1);
    write_byte(8'h77);
    chk("t3_level_after", level, 16);
    chk("t3_ovf", overflow, 0);
    chk("t3_send", uart_send, 1);
    wait_idle(3000);
    chk("t3_nsent", sent_log.size(), 18);
    if (sent_log.size() == 18) chk("t3_last", sent_log[17], 8'h77);
    chk("t3_bytes", bytes_sent, 18);

    // Reset while WAIT_DOWN with 5 bytes queued
    do_reset();
    resp_delay = 1; resp_hold = 30;
    for (int i = 0; i < 6; i++) write_byte(8'(8'h40 + i));
    repeat (3) tick();
    chk("t4_level_pre", level, 5);
    chk("t4_ubusy_pre", uart_busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_level", level, 0);
    chk("t4_empty", empty, 1);
    chk("t4_send", uart_send, 0);
    chk("t4_bytes", bytes_sent, 0);
    npulse = pulse_cyc.size();
    repeat (60) tick();
    chk("t4_no_pulses", pulse_cyc.size(), npulse);
    chk("t4_bytes_after", bytes_sent, 0);
    chk("t4_busy", busy, 0);

    // Randomized traffic, handshake timing and occasional reset
    do_reset();
    pct = 30;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        pct        = $urandom_range(5, 90);
        resp_delay = $urandom_range(1, 18);
        resp_hold  = $urandom_range(1, 8);
        resp_never = ($urandom_range(0, 9) == 0);
      end
      wr_en   = ($urandom_range(0, 99) < pct);
      wr_data = 8'($urandom);
      rst     = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 1'b0; wr_en = 1'b0; resp_never = 0; resp_delay = 1; resp_hold = 2;
    wait_idle(6000);

    // bytes_sent wrap from 0xFFFE
    do_reset();
    resp_delay = 1; resp_hold = 2;
    force dut.bytes_sent = 16'hFFFE;
    m_sent = 16'hFFFE;
    release dut.bytes_sent;
    tick();
    chk("t6_preload", bytes_sent, 16'hFFFE);
    for (int i = 0; i < 3; i++) write_byte(8'(8'hC0 + i));
    wait_idle(500);
    chk("t6_bytes", bytes_sent, 16'h0001);
    chk("t6_nvals", bs_val.size() >= 3, 1);
    if (bs_val.size() >= 3) begin
      chk("t6_ffff", bs_val[bs_val.size() - 3], 16'hFFFF);
      chk("t6_wrap", bs_val[bs_val.size() - 2], 16'h0000);
      chk("t6_one", bs_val[bs_val.size() - 1], 16'h0001);
    end
    chk("t6_ovf", overflow, 0);
    chk("t6_to", timeout_err, 0);
    chk("t6_nsent", sent_log.size(), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
